rv_regfile_sb: RTL and testbench
================================

# rv_regfile_sb

Parametrised multi-port general-purpose register file with an integrated per-register pending-write scoreboard, for the pipelined RV32I core. Provides NRD asynchronous read ports, two prioritised write ports (ALU writeback and late load return), and per-register busy status so issue logic can stall on RAW and WAW hazards. x0 is hard-wired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = log2(NREGS)
- NRD, 2, number of read ports (1–4)
- PMAX, 3, maximum outstanding writes per register (counter width CW = log2(PMAX+1))
- clk  in  1  rising-edge clock
- areset  in  1  asynchronous reset, active-high
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i address has ≥1 pending write
- wr_en  in  2  write enables; port 0 = writeback, port 1 = load return
- wr_addr  in  2*AW  write addresses
- wr_data  in  2*XLEN  write data
- iss_en  in  1  issue of an instruction writing iss_rd
- iss_rd  in  AW  destination register being issued
- iss_full  out  1  pending count of iss_rd equals PMAX; issue must not proceed
- sb_err  out  1  sticky: a write retired against a zero pending count

## Operation
- Storage: NREGS-1 registers of XLEN bits (x1..x(NREGS-1)); x0 reads 0.
- Reads combinational from rd_addr; rd_addr == 0 returns 0 and rd_busy = 0.
- Writes commit on rising clk when wr_en[p] and wr_addr[p] != 0.
- Both ports same nonzero address same cycle: port 1 data wins; pending count decremented by 2.
- Scoreboard: per-register CW-bit pending counter cnt[r], r ≥ 1.
  - Increment when iss_en and iss_rd == r and cnt[r] < PMAX.
  - Decrement by one per write port retiring to r.
  - Issue and retire same cycle, same r: net change (e.g. +1 −1 = unchanged).
  - iss_en while iss_full: increment suppressed; register data unaffected.
  - Decrement below 0: counter saturates at 0 and sb_err sets; cleared only by areset.
  - iss_rd == 0: ignored.
- rd_busy[i] = (cnt[rd_addr[i]] != 0), from the registered counter (current-cycle retire not yet reflected unless bypass compiled in).

## Timing
- Reset (async, immediate on areset high): all registers 0, all counters 0, sb_err 0; hence rd_data = 0, rd_busy = 0, iss_full = 0. Deassertion synchronous to clk at the design level.
- Read latency 0 cycles (combinational from address and state).
- Write-to-read visibility: cycle after the write edge (no bypass) or same cycle (bypass).
- Scoreboard updates on the same edge as writes; iss_full combinational from cnt[iss_rd].
- Reset mid-operation discards all pending counts; in-flight writes arriving after reset still write data and set sb_err.

## Configuration
- RV_REGFILE_BYPASS_EN defined: rd_data[i] forwards wr_data of a same-cycle write to rd_addr[i] (port 1 priority); rd_busy[i] computed from the counter minus same-cycle retires to that address (and excludes same-cycle issue).
- Undefined: rd_data and rd_busy come only from registered state.

## Structure
- Shared package rv_pkg: XLEN, REG_AW localparams, reg_addr_t and xlen_t typedefs.
- Sub-module rv_scoreboard: counter array, inc/dec/saturation, iss_full, sb_err, busy lookup. Top holds the data array, write priority and bypass mux.

## Test plan
- Reset: write x5=0xDEADBEEF, assert areset asynchronously mid-cycle -> rd_data for x5 = 0 immediately, rd_busy = 0, sb_err = 0.
- x0: wr_en[0]=1, wr_addr=0, wr_data=0xFFFFFFFF -> reading x0 returns 0, rd_busy 0; iss_rd=0 never raises iss_full.
- Dual write collision: both ports write x7 (0x11111111 on p0, 0x22222222 on p1) after two issues to x7 -> x7 = 0x22222222, cnt[x7] = 0, rd_busy 0.
- Scoreboard saturation: three issues to x3 -> iss_full = 1; fourth issue ignored; three retires -> rd_busy on x3 clears on the third edge, sb_err stays 0.
- Underflow: retire to x9 with cnt 0 -> sb_err = 1 and stays 1 until areset.
- Bypass (macro on/off): write x12 = 0x0000ABCD while reading x12 on both ports -> same-cycle 0x0000ABCD with macro, old value 0 without; next cycle 0x0000ABCD in both builds.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared definitions for the RV32I register file slice
// Purpose: default widths, address/data typedefs and the scoreboard retire
//          counting helper shared by rv_scoreboard and rv_regfile_sb.
// Ports:   none (package).
// Config:  RV_REGFILE_BYPASS_EN is consumed by the modules, not here.
package rv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xlen_t;

   // Number of write ports retiring to one register this cycle (0..2).
   function automatic int retire_count(input logic [1:0] en, input logic [1:0] hit);
      return int'(en[0] & hit[0]) + int'(en[1] & hit[1]);
   endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// rtl/rv_scoreboard.sv - per-register pending-write counters
// Purpose: tracks outstanding writes per architectural register so issue
//          logic can stall on RAW/WAW hazards; flags retire underflow.
// Ports:   clk, areset      clock and asynchronous active-high reset
//          rd_addr/rd_busy  busy lookup for each read port
//          wr_en/wr_addr    retiring writes (decrement)
//          iss_en/iss_rd    issuing writer (increment), iss_full when saturated
//          sb_err           sticky underflow flag
// Config:  RV_REGFILE_BYPASS_EN makes rd_busy discount same-cycle retires.
module rv_scoreboard
   import rv_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int PMAX  = 3,
   localparam int AW   = $clog2(NREGS),
   localparam int CW   = $clog2(PMAX + 1)
) (
   input  logic              clk,
   input  logic              areset,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy,
   input  logic [1:0]        wr_en,
   input  logic [2*AW-1:0]   wr_addr,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_rd,
   output logic              iss_full,
   output logic              sb_err
);

   logic [CW-1:0] cnt     [NREGS];
   logic [CW-1:0] cnt_nxt [NREGS];
   int            dec     [NREGS];
   int            net     [NREGS];
   logic          underflow;

   // Entry 0 is never updated, so x0 can never look busy or full.
   always_comb begin
      underflow = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         dec[r]     = 0;
         net[r]     = 0;
         cnt_nxt[r] = cnt[r];
         if (r != 0) begin
            dec[r] = retire_count(wr_en, {wr_addr[AW +: AW] == AW'(r),
                                          wr_addr[0  +: AW] == AW'(r)});
            // Increment is suppressed when already saturated at PMAX.
            net[r] = int'(cnt[r])
                   + int'(iss_en && (iss_rd == AW'(r)) && (int'(cnt[r]) < PMAX))
                   - dec[r];
            if (net[r] < 0) begin
               cnt_nxt[r] = '0;
               underflow  = 1'b1;
            end else begin
               cnt_nxt[r] = CW'(net[r]);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
         if (underflow) sb_err <= 1'b1;
      end
   end

   assign iss_full = (iss_rd != '0) && (int'(cnt[iss_rd]) == PMAX);

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_addr[i*AW +: AW] != '0) begin
`ifdef RV_REGFILE_BYPASS_EN
            rd_busy[i] = (int'(cnt[rd_addr[i*AW +: AW]]) - dec[rd_addr[i*AW +: AW]]) > 0;
`else
            rd_busy[i] = (cnt[rd_addr[i*AW +: AW]] != '0);
`endif
         end
      end
   end

endmodule

// File: rtl/rv_regfile_sb.sv
// rtl/rv_regfile_sb.sv - multi-port GPR file with pending-write scoreboard
// Purpose: NRD combinational read ports, two prioritised write ports
//          (port 1 = load return wins over port 0 = writeback), x0 fixed at 0,
//          and per-register busy status from rv_scoreboard.
// Ports:   clk, areset          clock and asynchronous active-high reset
//          rd_addr/rd_data      read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//          rd_busy              read address has a pending write
//          wr_en/wr_addr/wr_data two write ports
//          iss_en/iss_rd        issue of a writer, iss_full = must stall
//          sb_err               sticky retire-underflow flag
// Config:  RV_REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module rv_regfile_sb #(
   parameter int XLEN  = rv_pkg::XLEN,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int PMAX  = 3,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                areset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [1:0]          wr_en,
   input  logic [2*AW-1:0]     wr_addr,
   input  logic [2*XLEN-1:0]   wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_rd,
   output logic                iss_full,
   output logic                sb_err
);

   logic [XLEN-1:0] regs [NREGS];

   // Entry 0 is only ever reset, so it stays zero.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (wr_en[1] && (wr_addr[AW +: AW] == AW'(r)))
               regs[r] <= wr_data[XLEN +: XLEN];
            else if (wr_en[0] && (wr_addr[0 +: AW] == AW'(r)))
               regs[r] <= wr_data[0 +: XLEN];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_addr[i*AW +: AW] != '0) begin
            rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
`ifdef RV_REGFILE_BYPASS_EN
            if (wr_en[1] && (wr_addr[AW +: AW] == rd_addr[i*AW +: AW]))
               rd_data[i*XLEN +: XLEN] = wr_data[XLEN +: XLEN];
            else if (wr_en[0] && (wr_addr[0 +: AW] == rd_addr[i*AW +: AW]))
               rd_data[i*XLEN +: XLEN] = wr_data[0 +: XLEN];
`endif
         end
      end
   end

   rv_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .PMAX  (PMAX)
   ) u_sb (
      .clk      (clk),
      .areset   (areset),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .iss_full (iss_full),
      .sb_err   (sb_err)
   );

endmodule

// File: tb/tb_rv_regfile_sb.sv
// tb/tb_rv_regfile_sb.sv - scoreboard testbench for rv_regfile_sb
// Purpose: directed and random stimulus against a behavioural register file
//          model; expectations queued per cycle, compared by a monitor.
// Ports:   none (top-level bench).
// Config:  RV_REGFILE_BYPASS_EN selects the forwarding expectations.
module tb_rv_regfile_sb;

   localparam int AW   = 5;
   localparam int XL   = 32;
   localparam int PMAX = 3;

   logic            clk = 1'b0;
   logic            areset = 1'b1;
   logic [2*AW-1:0] rd_addr = '0;
   logic [2*XL-1:0] rd_data;
   logic [1:0]      rd_busy;
   logic [1:0]      wr_en = '0;
   logic [2*AW-1:0] wr_addr = '0;
   logic [2*XL-1:0] wr_data = '0;
   logic            iss_en = 1'b0;
   logic [AW-1:0]   iss_rd = '0;
   logic            iss_full;
   logic            sb_err;

   always #5 clk = ~clk;

   rv_regfile_sb dut (
      .clk      (clk),
      .areset   (areset),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .iss_full (iss_full),
      .sb_err   (sb_err)
   );

   typedef struct {
      logic [31:0] d0, d1;
      logic        b0, b1, full, err;
      int          id;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   bit          stim_done = 1'b0;
   int          item_id = 0;

   // Reference model: architectural values and outstanding-write counts.
   logic [31:0] m_mem [32];
   int          m_cnt [32];
   bit          m_err;

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_mem[r] = '0;
         m_cnt[r] = 0;
      end
      m_err = 1'b0;
   endtask

   function automatic int retires(int a);
      return ((wr_en[0] && int'(wr_addr[0 +: AW]) == a) ? 1 : 0)
           + ((wr_en[1] && int'(wr_addr[AW +: AW]) == a) ? 1 : 0);
   endfunction

   function automatic exp_t predict(int id);
      exp_t        e;
      int          a    [2];
      logic [31:0] d    [2];
      logic        b    [2];
      int          pend;
      a[0] = int'(rd_addr[0 +: AW]);
      a[1] = int'(rd_addr[AW +: AW]);
      for (int i = 0; i < 2; i++) begin
         d[i] = '0;
         b[i] = 1'b0;
         if (a[i] != 0) begin
            d[i] = m_mem[a[i]];
            pend = m_cnt[a[i]];
`ifdef RV_REGFILE_BYPASS_EN
            if (wr_en[1] && int'(wr_addr[AW +: AW]) == a[i]) d[i] = wr_data[XL +: XL];
            else if (wr_en[0] && int'(wr_addr[0 +: AW]) == a[i]) d[i] = wr_data[0 +: XL];
            pend = pend - retires(a[i]);
`endif
            b[i] = (pend > 0);
         end
      end
      e.d0   = d[0];
      e.d1   = d[1];
      e.b0   = b[0];
      e.b1   = b[1];
      e.full = (iss_rd != '0) && (m_cnt[int'(iss_rd)] == PMAX);
      e.err  = m_err;
      e.id   = id;
      return e;
   endfunction

   // Applies the effect of the coming clock edge to the model.
   task automatic model_update();
      int n;
      for (int r = 1; r < 32; r++) begin
         n = m_cnt[r] + ((iss_en && int'(iss_rd) == r && m_cnt[r] < PMAX) ? 1 : 0) - retires(r);
         if (n < 0) begin
            n     = 0;
            m_err = 1'b1;
         end
         m_cnt[r] = n;
      end
      if (wr_en[0] && wr_addr[0 +: AW] != '0) m_mem[int'(wr_addr[0 +: AW])] = wr_data[0 +: XL];
      if (wr_en[1] && wr_addr[AW +: AW] != '0) m_mem[int'(wr_addr[AW +: AW])] = wr_data[XL +: XL];
   endtask

   task automatic cycle(input bit we0, input int a0, input logic [31:0] d0,
                        input bit we1, input int a1, input logic [31:0] d1,
                        input bit ie, input int ir, input int r0, input int r1);
      @(negedge clk);
      wr_en   = {we1, we0};
      wr_addr = {AW'(a1), AW'(a0)};
      wr_data = {d1, d0};
      iss_en  = ie;
      iss_rd  = AW'(ir);
      rd_addr = {AW'(r1), AW'(r0)};
      #1;
      q.push_back(predict(item_id));
      item_id++;
      model_update();
   endtask

   // Raises areset mid-cycle; outputs must clear without waiting for an edge.
   task automatic do_reset(input int r0, input int r1);
      @(negedge clk);
      wr_en   = '0;
      iss_en  = 1'b0;
      iss_rd  = '0;
      rd_addr = {AW'(r1), AW'(r0)};
      #1 areset = 1'b1;
      #1;
      model_reset();
      q.push_back(predict(item_id));
      item_id++;
      @(posedge clk);
      #1 areset = 1'b0;
   endtask

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (item %0d): got %h expected %h", name, id, act, exp);
      end
   endtask

   // Stimulus
   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 areset = 1'b0;

      cycle(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);

      cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
      do_reset(5, 5);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

      cycle(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
      cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
      cycle(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 7, 7, 7);
      cycle(0, 0, 0, 0, 0, 0, 0, 7, 7, 7);

      repeat (3) cycle(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
      cycle(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
      repeat (3) cycle(1, 3, $urandom, 0, 0, 0, 0, 3, 3, 3);
      cycle(0, 0, 0, 0, 0, 0, 0, 3, 3, 3);

      cycle(0, 0, 0, 1, 9, 32'h0000AAAA, 0, 0, 9, 9);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 9, 9, 3);

      cycle(1, 12, 32'h0000ABCD, 0, 0, 0, 0, 0, 12, 12);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 12, 12);

      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 99) == 0)
            do_reset($urandom_range(0, 15), $urandom_range(0, 15));
         else
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15));
      end

      do_reset(9, 12);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 12);
      stim_done = 1'b1;
   end

   // Monitor: outputs are settled 3 time units after each negedge.
   initial begin
      exp_t e;
      int   budget;
      budget = 0;
      while (!(stim_done && q.size() == 0)) begin
         @(negedge clk);
         #3;
         while (q.size() > 0) begin
            e = q.pop_front();
            check("rd_data0", e.id, rd_data[0 +: XL], e.d0);
            check("rd_data1", e.id, rd_data[XL +: XL], e.d1);
            check("rd_busy0", e.id, 32'(rd_busy[0]), 32'(e.b0));
            check("rd_busy1", e.id, 32'(rd_busy[1]), 32'(e.b1));
            check("iss_full", e.id, 32'(iss_full), 32'(e.full));
            check("sb_err", e.id, 32'(sb_err), 32'(e.err));
         end
         budget++;
         if (budget > 20000) begin
            n_checks++;
            n_errors++;
            $display("FAIL watchdog: got %0d cycles expected stimulus to finish", budget);
            break;
         end
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
